data_packer: RTL and testbench
==============================

Name: data_packer

Overview:
- Sits directly downstream of the vector-vector ALU stage and upstream of the trace buffer.
- For each chain, it either drops or commits the incoming vector, according to per-chain firmware.
- Committed vectors are truncated to a programmable element count and packed densely into N-element trace words, so that scalar results (size 1) do not waste trace-buffer width.
- A flush request emits any partially filled word, zero-padded.

Parameters:
- N, 8, elements per vector and per packed output word.
- DATA_WIDTH, 32, bits per element.
- MAX_CHAINS, 4, number of firmware chains.
- PERSONAL_CONFIG_ID, 0, configId value that addresses this block.
- INITIAL_FIRMWARE_COMMIT, all 0, 8-bit per-chain reset value for commit enable.
- INITIAL_FIRMWARE_SIZE, all 0, 8-bit per-chain reset value for element count.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- tracing, input, 1, when low, valid_in is ignored.
- valid_in, input, 1, input vector is valid.
- eof_in, input, 1, end of frame; carried for reference only and not used for packing.
- bof_in, input, 1, beginning of frame; carried for reference only and not used for packing.
- chainId_in, input, $clog2(MAX_CHAINS), selects the firmware entry.
- vector_in, input, N x DATA_WIDTH, input vector, element 0 first.
- flush, input, 1, single-cycle request to emit the partial word.
- configId, input, 8, configuration target.
- configData, input, 8, configuration byte.
- vector_out, output, N x DATA_WIDTH, packed word.
- valid_out, output, 1, vector_out is valid for exactly this cycle.
- count_out, output, $clog2(N)+1, number of meaningful elements in vector_out (1..N).

Behaviour:

Reset (synchronous):
- valid_out=0, vector_out=all zeros, count_out=0.
- fill=0, flush_pending=0, cfg_ptr=0.
- Firmware registers reload the INITIAL_* values.
- Reset asserted mid-packing discards the partial word without emitting it.

Configuration:
- When configId==PERSONAL_CONFIG_ID, each cycle writes configData into the entry selected by cfg_ptr, then increments cfg_ptr.
- Write order: commit[0], size[0], commit[1], size[1], ...
- Even cfg_ptr values select a commit entry (bit 0 used); odd values select a size entry.
- cfg_ptr saturates after 2*MAX_CHAINS writes; further writes are ignored.
- cfg_ptr returns to 0 in any cycle where configId!=PERSONAL_CONFIG_ID.
- Configuration writes take effect from the next cycle.

Effective size:
- s = size[chainId_in]; s=0 or s>N is treated as N.

Accept condition:
- accept = tracing & valid_in & commit[chainId_in][0].
- A non-accepted vector is dropped. The block never backpressures.

Packing:
- Internal holding buffer buf[0..N-1] with fill count 0..N-1 (fill<N always holds between cycles).
- On accept, vector_in[0..s-1] is appended at positions fill..fill+s-1 of a virtual 2N concatenation.
- If fill+s < N:
  - fill <= fill+s; no output.
- If fill+s >= N:
  - Next cycle valid_out=1, vector_out = the first N elements of the concatenation, count_out=N.
  - The remainder (fill+s-N elements, 0..N-1) moves to buf[0..]; fill <= fill+s-N.

Latency:
- Exactly 1 cycle from the accepting edge to valid_out.
- Back-to-back full-size accepts produce one word every cycle.

Flush:
- flush (or flush_pending) with fill>0 and no full word produced this cycle:
  - Next cycle valid_out=1, vector_out = buf[0..fill-1] followed by zeros, count_out=fill.
  - fill <= 0, flush_pending <= 0.
- flush with fill==0 and no accept: no output; the request is cleared.

Simultaneous flush and accept:
- The accept is appended first.
- If that produces a full word, the full word is emitted and flush_pending <= 1 when a remainder exists. The remainder is then flushed as a padded word on the following cycle, unless a new accept that cycle fills the word again; in that case the flush stays pending.
- If no full word is produced, the combined partial word is flushed padded.

Tracing:
- flush is honoured regardless of tracing.
- tracing low never clears buf.

Outputs when idle:
- valid_out=0 in every cycle without an emission.
- vector_out and count_out hold their last value.

Arithmetic:
- fill and count arithmetic use $clog2(N)+2 bits; no wrap is possible.
- Data is passed bit-exact, with no arithmetic on elements.

Test Plan (N=8, DATA_WIDTH=32, MAX_CHAINS=4):
1. Reset, then configure commit[0]=1, size[0]=8; send vector 0..7 on chain 0 → next cycle valid_out=1, vector_out=0..7, count_out=8; fill=0.
2. size[1]=1, commit[1]=1; send 8 vectors on chain 1, each with element0=10..17 → a single output word 10..17 with count_out=8, one cycle after the 8th input; no output before that.
3. size[2]=3; send three vectors with element0..2 = {1,2,3},{4,5,6},{7,8,9} → word 1..8 count 8 after the 3rd vector; fill=1 holding 9; then flush → word {9,0,0,0,0,0,0,0}, count_out=1.
4. commit[3]=0; send 5 vectors on chain 3 → no valid_out ever; fill unchanged. Repeat with tracing=0 on chain 0 → no output.
5. fill=6 (two size-3 vectors), then a size-3 vector together with flush → full word (count 8) next cycle, then the padded word with count_out=1 the cycle after. Also assert reset while fill=5 → no output; fill=0.
6. Configuration: configId=PERSONAL_CONFIG_ID for 8 cycles writing 1,2,1,4,0,0,1,8, then configId=0xFF → readback by traffic shows sizes 2/4/-/8 and commit pattern 1,1,0,1; a 9th write while still selected is ignored.

Source files
------------

// File: rtl/data_packer.sv
// Drops or commits incoming ALU vectors per firmware chain, truncates committed
// vectors to a programmable element count and packs them densely into N-element trace words.
module data_packer #(
   parameter int unsigned N          = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_CHAINS = 4,
   parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
   parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_COMMIT = '0,
   parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_SIZE   = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           tracing,
   input  logic                           valid_in,
   input  logic                           eof_in,
   input  logic                           bof_in,
   input  logic [$clog2(MAX_CHAINS)-1:0]  chainId_in,
   input  logic [N*DATA_WIDTH-1:0]        vector_in,
   input  logic                           flush,
   input  logic [7:0]                     configId,
   input  logic [7:0]                     configData,
   output logic [N*DATA_WIDTH-1:0]        vector_out,
   output logic                           valid_out,
   output logic [$clog2(N):0]             count_out
);

   localparam int unsigned FW = $clog2(N) + 2;
   localparam int unsigned CW = $clog2(N) + 1;
   localparam int unsigned PW = $clog2(2*MAX_CHAINS) + 1;

   logic                  commit_q [MAX_CHAINS];
   logic                  commit_d [MAX_CHAINS];
   logic [7:0]            size_q   [MAX_CHAINS];
   logic [7:0]            size_d   [MAX_CHAINS];
   logic [PW-1:0]         cfg_ptr_q, cfg_ptr_d;

   logic [DATA_WIDTH-1:0] hold_q   [N];
   logic [DATA_WIDTH-1:0] hold_d   [N];
   logic [FW-1:0]         fill_q, fill_d;
   logic                  pend_q, pend_d;

   logic [N*DATA_WIDTH-1:0] vector_q, vector_d;
   logic                    valid_q, valid_d;
   logic [CW-1:0]           count_q, count_d;

   logic [DATA_WIDTH-1:0] vec_el [N];
   logic [DATA_WIDTH-1:0] cat    [2*N];
   logic [7:0]            sel_size;
   logic [FW-1:0]         eff_size;
   logic [FW-1:0]         total;
   logic                  accept;
   logic                  flush_req;
   logic                  unused_c;

   assign unused_c = eof_in ^ bof_in;

   // Sequential firmware writes: commit[0], size[0], commit[1], ... saturating at the end
   always_comb begin
      cfg_ptr_d = cfg_ptr_q;
      commit_d  = commit_q;
      size_d    = size_q;
      if (configId == PERSONAL_CONFIG_ID) begin
         if (cfg_ptr_q < PW'(2*MAX_CHAINS)) begin
            for (int c = 0; c < int'(MAX_CHAINS); c++) begin
               if (cfg_ptr_q == PW'(2*c))     commit_d[c] = configData[0];
               if (cfg_ptr_q == PW'(2*c + 1)) size_d[c]   = configData;
            end
            cfg_ptr_d = cfg_ptr_q + PW'(1);
         end
      end else begin
         cfg_ptr_d = '0;
      end
   end

   always_comb begin
      sel_size = size_q[chainId_in];
      eff_size = (sel_size == 8'd0 || sel_size > 8'(N)) ? FW'(N) : FW'(sel_size);
      accept   = tracing & valid_in & commit_q[chainId_in];
      total    = fill_q + (accept ? eff_size : FW'(0));
   end

   // Virtual 2N concatenation: held elements followed by the truncated new vector
   always_comb begin
      for (int k = 0; k < int'(N); k++) begin
         vec_el[k] = vector_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int i = 0; i < int'(N); i++) begin
         cat[i] = (FW'(i) < fill_q) ? hold_q[i] : '0;
      end
      for (int i = int'(N); i < int'(2*N); i++) begin
         cat[i] = '0;
      end
      for (int k = 0; k < int'(N); k++) begin
         if (accept && FW'(k) < eff_size) begin
            for (int i = 0; i < int'(2*N); i++) begin
               if (FW'(i) == fill_q + FW'(k)) cat[i] = vec_el[k];
            end
         end
      end
   end

   // A full word has priority; a flush request waits behind it while a remainder exists
   always_comb begin
      fill_d    = fill_q;
      pend_d    = pend_q;
      hold_d    = hold_q;
      valid_d   = 1'b0;
      vector_d  = vector_q;
      count_d   = count_q;
      flush_req = flush | pend_q;
      if (total >= FW'(N)) begin
         valid_d = 1'b1;
         count_d = CW'(N);
         for (int i = 0; i < int'(N); i++) begin
            vector_d[i*DATA_WIDTH +: DATA_WIDTH] = cat[i];
            hold_d[i] = cat[i + int'(N)];
         end
         fill_d = total - FW'(N);
         pend_d = flush_req && (fill_d != '0);
      end else if (flush_req && total != '0) begin
         valid_d = 1'b1;
         count_d = CW'(total);
         for (int i = 0; i < int'(N); i++) begin
            vector_d[i*DATA_WIDTH +: DATA_WIDTH] = cat[i];
         end
         fill_d = '0;
         pend_d = 1'b0;
      end else begin
         for (int i = 0; i < int'(N); i++) begin
            hold_d[i] = cat[i];
         end
         fill_d = total;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < int'(MAX_CHAINS); c++) begin
            commit_q[c] <= INITIAL_FIRMWARE_COMMIT[c*8];
            size_q[c]   <= INITIAL_FIRMWARE_SIZE[c*8 +: 8];
         end
         for (int i = 0; i < int'(N); i++) begin
            hold_q[i] <= '0;
         end
         cfg_ptr_q <= '0;
         fill_q    <= '0;
         pend_q    <= 1'b0;
         valid_q   <= 1'b0;
         vector_q  <= '0;
         count_q   <= '0;
      end else begin
         commit_q  <= commit_d;
         size_q    <= size_d;
         hold_q    <= hold_d;
         cfg_ptr_q <= cfg_ptr_d;
         fill_q    <= fill_d;
         pend_q    <= pend_d;
         valid_q   <= valid_d;
         vector_q  <= vector_d;
         count_q   <= count_d;
      end
   end

   assign vector_out = vector_q;
   assign valid_out  = valid_q;
   assign count_out  = count_q;

endmodule

// File: tb/tb_data_packer.sv
// Randomized and directed checks of data_packer against a queue-based element model.
module tb_data_packer;

   localparam int N  = 8;
   localparam int DW = 32;
   localparam int MC = 4;
   localparam int VW = N*DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          tracing;
   logic          valid_in;
   logic          eof_in;
   logic          bof_in;
   logic [1:0]    chain_id;
   logic [VW-1:0] vec_in;
   logic          flush;
   logic [7:0]    config_id;
   logic [7:0]    config_data;
   logic [VW-1:0] vector_out;
   logic          valid_out;
   logic [3:0]    count_out;

   always #5 clk = ~clk;

   data_packer #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)) dut (
      .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in),
      .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chain_id), .vector_in(vec_in),
      .flush(flush), .configId(config_id), .configData(config_data),
      .vector_out(vector_out), .valid_out(valid_out), .count_out(count_out)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: a plain queue of committed elements
   logic [DW-1:0] mq[$];
   bit            m_pend;
   int            m_ptr;
   int            m_commit [MC];
   int            m_size   [MC];
   bit            e_valid;
   logic [VW-1:0] e_vec;
   int            e_cnt;

   task automatic model_edge();
      int s;
      bit acc;
      bit freq;
      if (reset) begin
         mq.delete();
         m_pend = 0;
         m_ptr  = 0;
         for (int c = 0; c < MC; c++) begin
            m_commit[c] = 0;
            m_size[c]   = 0;
         end
         e_valid = 0;
         e_vec   = '0;
         e_cnt   = 0;
         return;
      end
      s = m_size[chain_id];
      if (s == 0 || s > N) s = N;
      acc  = tracing && valid_in && ((m_commit[chain_id] & 1) != 0);
      freq = flush || m_pend;
      if (acc) for (int k = 0; k < s; k++) mq.push_back(vec_in[k*DW +: DW]);
      e_valid = 0;
      if (mq.size() >= N) begin
         e_valid = 1;
         e_cnt   = N;
         for (int i = 0; i < N; i++) e_vec[i*DW +: DW] = mq.pop_front();
         m_pend = freq && (mq.size() > 0);
      end else if (freq && mq.size() > 0) begin
         e_valid = 1;
         e_cnt   = mq.size();
         e_vec   = '0;
         for (int i = 0; i < e_cnt; i++) e_vec[i*DW +: DW] = mq[i];
         mq.delete();
         m_pend = 0;
      end else begin
         m_pend = 0;
      end
      if (config_id == 8'h00) begin
         if (m_ptr < 2*MC) begin
            if (m_ptr % 2 == 0) m_commit[m_ptr/2] = int'(config_data);
            else                m_size[m_ptr/2]   = int'(config_data);
            m_ptr++;
         end
      end else begin
         m_ptr = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("valid_out", VW'(valid_out), VW'(e_valid));
      chk("count_out", VW'(count_out), VW'(e_cnt));
      chk("vector_out", vector_out, e_vec);
   endtask

   function automatic logic [VW-1:0] ramp(input int base);
      logic [VW-1:0] v;
      for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + k);
      return v;
   endfunction

   task automatic send(input int ch, input logic [VW-1:0] v, input bit fl);
      valid_in = 1'b1;
      chain_id = 2'(ch);
      vec_in   = v;
      flush    = fl;
      step();
      valid_in = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic cfg_write(input logic [71:0] bytes, input int n);
      for (int i = 0; i < n; i++) begin
         config_id   = 8'h00;
         config_data = bytes[8*i +: 8];
         step();
      end
      config_id = 8'hFF;
   endtask

   initial begin
      reset = 1'b1; tracing = 1'b1; valid_in = 1'b0; eof_in = 1'b0; bof_in = 1'b0;
      chain_id = '0; vec_in = '0; flush = 1'b0; config_id = 8'hFF; config_data = '0;
      step();
      step();
      reset = 1'b0;
      step();

      // commit/size: ch0 1/8, ch1 1/1, ch2 1/3, ch3 0/0, then one ignored extra write
      cfg_write(72'h55_00_00_03_01_01_01_08_01, 9);
      step();

      send(0, ramp(0), 1'b0);
      step();
      for (int i = 0; i < 8; i++) send(1, ramp(10 + i), 1'b0);
      step();
      send(2, ramp(1), 1'b0);
      send(2, ramp(4), 1'b0);
      send(2, ramp(7), 1'b0);
      flush = 1'b1; step(); flush = 1'b0;
      step();
      for (int i = 0; i < 5; i++) send(3, ramp(100 + i), 1'b0);
      tracing = 1'b0;
      for (int i = 0; i < 3; i++) send(0, ramp(200 + i), 1'b0);
      tracing = 1'b1;
      step();

      send(2, ramp(20), 1'b0);
      send(2, ramp(30), 1'b0);
      send(2, ramp(40), 1'b1);
      step();
      step();

      send(1, ramp(50), 1'b0);
      send(1, ramp(51), 1'b0);
      send(2, ramp(52), 1'b0);
      reset = 1'b1; step(); reset = 1'b0;
      flush = 1'b1; step(); flush = 1'b0;

      cfg_write(72'h00_08_01_00_00_04_01_02_01, 9);
      for (int i = 0; i < 12; i++) send(i % 4, ramp(300 + 10*i), 1'b0);
      flush = 1'b1; step(); flush = 1'b0;
      step();

      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 149) == 0) begin
            logic [71:0] b;
            for (int j = 0; j < 9; j++)
               b[8*j +: 8] = (j % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 10));
            valid_in = 1'b0;
            flush    = 1'b0;
            cfg_write(b, $urandom_range(7, 9));
         end
         reset     = ($urandom_range(0, 399) == 0);
         tracing   = ($urandom_range(0, 7) != 0);
         valid_in  = ($urandom_range(0, 3) != 0);
         chain_id  = 2'($urandom_range(0, 3));
         for (int k = 0; k < N; k++) vec_in[k*DW +: DW] = $urandom;
         flush     = ($urandom_range(0, 9) == 0);
         eof_in    = 1'($urandom);
         bof_in    = 1'($urandom);
         config_id = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'hFF;
         step();
         if (reset) begin
            reset = 1'b0;
            valid_in = 1'b0;
            cfg_write({8'h00, 8'h08, 8'h01, 8'h05, 8'h01, 8'h03, 8'h01, 8'h08, 8'h01}, 8);
         end
      end
      reset = 1'b0; valid_in = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
